// File: rtl/circle_pkg.sv
// Shared definitions for the hit-circle game: state encodings, key codes,
// default timing and the per-type key and screen-position lookups.
package circle_pkg;

  // FSM state encodings, kept as plain constants so older blocks can share them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_APPROACH  = 2'd1;
  localparam state_t ST_HIT_SHOW  = 2'd2;
  localparam state_t ST_MISS_SHOW = 2'd3;

  // USB HID keycodes used by the game.
  localparam logic [7:0] KEY_NONE  = 8'd0;
  localparam logic [7:0] KEY_A     = 8'd4;
  localparam logic [7:0] KEY_S     = 8'd22;
  localparam logic [7:0] KEY_D     = 8'd7;
  localparam logic [7:0] KEY_F     = 8'd9;
  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_Q     = 8'd20;

  // Default timing, shared with the statemachine and the color mapper.
  localparam int DEF_APPROACH_FRAMES = 60;
  localparam int DEF_HIT_WINDOW      = 12;
  localparam int DEF_SHOW_FRAMES     = 20;
  localparam int DEF_HEALTH_INIT     = 4;
  localparam int DEF_HEALTH_MAX      = 8;

  // Key expected for a given circle type.
  function automatic logic [7:0] key_for_type(input logic [1:0] ctype);
    case (ctype)
      2'd0:    key_for_type = KEY_A;
      2'd1:    key_for_type = KEY_S;
      2'd2:    key_for_type = KEY_D;
      default: key_for_type = KEY_F;
    endcase
  endfunction

  // Circle centre X for a given circle type; the four lanes share one row.
  function automatic logic [9:0] x_for_type(input logic [1:0] ctype);
    case (ctype)
      2'd0:    x_for_type = 10'd160;
      2'd1:    x_for_type = 10'd280;
      2'd2:    x_for_type = 10'd400;
      default: x_for_type = 10'd520;
    endcase
  endfunction

  // Circle centre Y for a given circle type.
  function automatic logic [9:0] y_for_type(input logic [1:0] ctype);
    y_for_type = (ctype == 2'd0) ? 10'd240 : 10'd240;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns a level keycode into a one-cycle press pulse: a non-zero code that
// differs from last cycle's code. A held key therefore yields one pulse.
module key_edge_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_i,
  output logic       edge_o
);

  logic [7:0] key_prev_q;

  // Remember the previous keycode every cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) key_prev_q <= 8'd0;
    else        key_prev_q <= key_i;
  end

  assign edge_o = (key_i != 8'd0) && (key_i != key_prev_q);

endmodule

// File: rtl/circle_judge.sv
// Responder side of the spawn interface: runs one hit-circle through its
// approach, judges the player's key press, shows the result, then reports
// out_of_bounds and the updated health back to the game FSM.
module circle_judge
  import circle_pkg::*;
#(
  parameter int APPROACH_FRAMES = DEF_APPROACH_FRAMES,
  parameter int HIT_WINDOW      = DEF_HIT_WINDOW,
  parameter int SHOW_FRAMES     = DEF_SHOW_FRAMES,
  parameter int HEALTH_INIT     = DEF_HEALTH_INIT,
  parameter int HEALTH_MAX      = DEF_HEALTH_MAX
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       main,
  input  logic       spawn,
  input  logic [1:0] circletype,
  input  logic [7:0] keycode,
  output logic       out_of_bounds,
  output logic [3:0] health,
  output logic [7:0] score,
  output logic       circle_active,
  output logic [9:0] circle_x,
  output logic [9:0] circle_y,
  output logic [7:0] approach_count,
  output logic       hit_flag,
  output logic       miss_flag
);

  state_t     state_q, state_d;
  logic [7:0] appr_q, appr_d;
  logic [7:0] show_q, show_d;
  logic [1:0] type_q, type_d;
  logic [3:0] health_q, health_d;
  logic [7:0] score_q, score_d;
  logic       oob_d;
  logic       oob_q, active_q, hit_q, miss_q;
  logic [9:0] x_q, y_q;
  logic       key_edge;
  logic       go_hit, go_miss;

  key_edge_detect u_key_edge (
    .clk   (Clk),
    .rst_n (Reset_n),
    .key_i (keycode),
    .edge_o(key_edge)
  );

  // Next-state logic: judge keys and ticks against the registered counters.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    appr_d   = appr_q;
    show_d   = show_q;
    type_d   = type_q;
    health_d = health_q;
    score_d  = score_q;
    oob_d    = 1'b0;
    go_hit   = 1'b0;
    go_miss  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (spawn) begin
          type_d  = circletype;
          appr_d  = 8'(APPROACH_FRAMES);
          state_d = ST_APPROACH;
        end
      end
      ST_APPROACH: begin
        // A key press wins over a simultaneous tick; the tick is dropped.
        if (key_edge) begin
          if (keycode == key_for_type(type_q) && appr_q <= 8'(HIT_WINDOW))
            go_hit = 1'b1;
          else
            go_miss = 1'b1;
        end else if (frame_tick) begin
          if (appr_q == 8'd0) go_miss = 1'b1;
          else                appr_d  = appr_q - 8'd1;
        end
      end
      default: begin
        // Result display: count frames down, then release the circle.
        if (frame_tick) begin
          if (show_q == 8'd0) begin
            state_d = ST_IDLE;
            oob_d   = 1'b1;
          end else begin
            show_d = show_q - 8'd1;
          end
        end
      end
    endcase

    if (go_hit) begin
      state_d  = ST_HIT_SHOW;
      show_d   = 8'(SHOW_FRAMES);
      health_d = (health_q >= 4'(HEALTH_MAX)) ? 4'(HEALTH_MAX) : health_q + 4'd1;
      score_d  = (score_q == 8'd255) ? 8'd255 : score_q + 8'd1;
    end
    if (go_miss) begin
      state_d  = ST_MISS_SHOW;
      show_d   = 8'(SHOW_FRAMES);
      health_d = (health_q == 4'd0) ? 4'd0 : health_q - 4'd1;
    end

    // The main screen pins the block in its new-game state and drops spawns.
    if (main) begin
      state_d  = ST_IDLE;
      appr_d   = 8'd0;
      show_d   = 8'd0;
      health_d = 4'(HEALTH_INIT);
      score_d  = 8'd0;
      oob_d    = 1'b0;
      type_d   = type_q;
    end
  end

  // State, counters and registered outputs, all derived from next state.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      appr_q   <= 8'd0;
      show_q   <= 8'd0;
      type_q   <= 2'd0;
      health_q <= 4'(HEALTH_INIT);
      score_q  <= 8'd0;
      oob_q    <= 1'b0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      x_q      <= x_for_type(2'd0);
      y_q      <= y_for_type(2'd0);
    end else begin
      state_q  <= state_d;
      appr_q   <= appr_d;
      show_q   <= show_d;
      type_q   <= type_d;
      health_q <= health_d;
      score_q  <= score_d;
      oob_q    <= oob_d;
      active_q <= (state_d != ST_IDLE);
      hit_q    <= (state_d == ST_HIT_SHOW);
      miss_q   <= (state_d == ST_MISS_SHOW);
      x_q      <= x_for_type(type_d);
      y_q      <= y_for_type(type_d);
    end
  end

  assign out_of_bounds  = oob_q;
  assign health         = health_q;
  assign score          = score_q;
  assign circle_active  = active_q;
  assign circle_x       = x_q;
  assign circle_y       = y_q;
  assign approach_count = appr_q;
  assign hit_flag       = hit_q;
  assign miss_flag      = miss_q;

endmodule

// File: tb/tb_circle_judge.sv
// Directed-vector bench for circle_judge with hand-computed expectations.
module tb_circle_judge;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       main = 1'b0;
  logic       spawn = 1'b0;
  logic [1:0] circletype = 2'd0;
  logic [7:0] keycode = 8'd0;
  logic       out_of_bounds;
  logic [3:0] health;
  logic [7:0] score;
  logic       circle_active;
  logic [9:0] circle_x;
  logic [9:0] circle_y;
  logic [7:0] approach_count;
  logic       hit_flag;
  logic       miss_flag;

  int check_count = 0;
  int error_count = 0;
  int oob_cnt = 0;

  circle_judge dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .main          (main),
    .spawn         (spawn),
    .circletype    (circletype),
    .keycode       (keycode),
    .out_of_bounds (out_of_bounds),
    .health        (health),
    .score         (score),
    .circle_active (circle_active),
    .circle_x      (circle_x),
    .circle_y      (circle_y),
    .approach_count(approach_count),
    .hit_flag      (hit_flag),
    .miss_flag     (miss_flag)
  );

  initial forever #5 Clk = ~Clk;

  // Count every cycle in which out_of_bounds is high.
  always @(posedge Clk) if (out_of_bounds === 1'b1) oob_cnt <= oob_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs are read 1 ns after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // n frames, each a tick cycle followed by a quiet cycle.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic do_spawn(input logic [1:0] t);
    circletype = t; spawn = 1'b1; step();
    spawn = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k; step();
  endtask

  // Result shows for 21 ticks, releasing exactly one out_of_bounds pulse.
  task automatic finish_show(input string tag);
    int base;
    base = oob_cnt;
    frames(20);
    check({tag, "_oob_early"}, oob_cnt - base, 0);
    check({tag, "_still_on"}, circle_active, 1);
    frame_tick = 1'b1; step();
    frame_tick = 1'b0;
    check({tag, "_oob_pulse"}, out_of_bounds, 1);
    step();
    check({tag, "_oob_once"}, out_of_bounds, 0);
    check({tag, "_oob_count"}, oob_cnt - base, 1);
    check({tag, "_idle"}, circle_active, 0);
  endtask

  // Hit lane 0 at approach_count 12, the last count inside the window.
  task automatic hit_at_window(input int exp_health, input int exp_score, input string tag);
    do_spawn(2'd0);
    frames(48);
    check({tag, "_cnt"}, approach_count, 12);
    press(8'd4);
    check({tag, "_hit"}, hit_flag, 1);
    check({tag, "_health"}, health, exp_health);
    check({tag, "_score"}, score, exp_score);
    keycode = 8'd0;
    finish_show(tag);
  endtask

  initial begin
    int base;

    // Reset for two cycles.
    step(); step();
    check("rst_health", health, 4);
    check("rst_score", score, 0);
    check("rst_flags", {out_of_bounds, circle_active, hit_flag, miss_flag}, 0);
    check("rst_count", approach_count, 0);
    Reset_n = 1'b1;
    step();

    // Spawn type 1.
    do_spawn(2'd1);
    check("sp1_active", circle_active, 1);
    check("sp1_x", circle_x, 280);
    check("sp1_y", circle_y, 240);
    check("sp1_count", approach_count, 60);

    // main returns to new game and ignores spawn.
    main = 1'b1; spawn = 1'b1; step();
    spawn = 1'b0; step();
    check("main_active", circle_active, 0);
    check("main_health", health, 4);
    main = 1'b0;

    // Type 2 hit at count 10.
    do_spawn(2'd2);
    frames(50);
    check("t2_count", approach_count, 10);
    press(8'd7);
    check("t2_hit", hit_flag, 1);
    check("t2_miss", miss_flag, 0);
    check("t2_health", health, 5);
    check("t2_score", score, 1);
    keycode = 8'd0;
    finish_show("t2");

    // Type 0 expiry: 60 ticks to reach 0, the 61st misses.
    do_spawn(2'd0);
    frames(60);
    check("exp_count0", approach_count, 0);
    check("exp_nomiss", miss_flag, 0);
    frames(1);
    check("exp_miss", miss_flag, 1);
    check("exp_health", health, 4);
    finish_show("exp");

    // Early correct key at count 30 -> miss.
    do_spawn(2'd3);
    frames(30);
    press(8'd9);
    check("early_miss", miss_flag, 1);
    check("early_health", health, 3);
    keycode = 8'd0;
    finish_show("early");

    // Wrong key at count 5 -> miss.
    do_spawn(2'd3);
    frames(55);
    check("wrong_count", approach_count, 5);
    press(8'd4);
    check("wrong_miss", miss_flag, 1);
    check("wrong_health", health, 2);
    keycode = 8'd0;
    finish_show("wrong");

    // Drain health to 0 with early presses, then one more miss.
    for (int i = 0; i < 3; i++) begin
      do_spawn(2'd0);
      press(8'd4);
      keycode = 8'd0;
      check("drain_miss", miss_flag, 1);
      check("drain_health", health, (i < 2) ? 1 - i : 0);
      finish_show("drain");
    end

    // Back to health 4, then hits up to the ceiling.
    main = 1'b1; step();
    main = 1'b0; step();
    check("new_health", health, 4);
    check("new_score", score, 0);

    // First hit, with the key held for 100 cycles afterwards.
    do_spawn(2'd0);
    frames(48);
    press(8'd4);
    check("hold_hit", hit_flag, 1);
    check("hold_health", health, 5);
    repeat (100) step();
    check("hold_score", score, 1);
    finish_show("hold");
    do_spawn(2'd0);
    frames(48);
    check("hold_no_judge", {hit_flag, miss_flag}, 0);
    check("hold_still_appr", circle_active, 1);
    keycode = 8'd0; step();
    press(8'd4);
    check("repress_hit", hit_flag, 1);
    check("repress_health", health, 6);
    keycode = 8'd0;
    finish_show("repress");

    hit_at_window(7, 3, "h3");
    hit_at_window(8, 4, "h4");
    hit_at_window(8, 5, "hsat");

    // Count 13 is just outside the window -> miss.
    do_spawn(2'd0);
    frames(47);
    check("w13_count", approach_count, 13);
    press(8'd4);
    check("w13_miss", miss_flag, 1);
    check("w13_health", health, 7);
    keycode = 8'd0;
    finish_show("w13");

    // Spawn during APPROACH is dropped.
    do_spawn(2'd1);
    frames(5);
    do_spawn(2'd3);
    check("dup_x", circle_x, 280);
    check("dup_count", approach_count, 55);
    frames(55);
    check("same_count0", approach_count, 0);

    // Key edge and frame_tick together at count 0 with the right key.
    keycode = 8'd22; frame_tick = 1'b1; step();
    frame_tick = 1'b0;
    check("same_hit", hit_flag, 1);
    check("same_miss", miss_flag, 0);
    check("same_health", health, 8);
    check("same_score", score, 6);
    keycode = 8'd0;

    // Reset mid-HIT_SHOW: back to IDLE with no pulse.
    frames(3);
    base = oob_cnt;
    Reset_n = 1'b0; step();
    check("mrst_active", circle_active, 0);
    check("mrst_hit", hit_flag, 0);
    check("mrst_health", health, 4);
    check("mrst_score", score, 0);
    Reset_n = 1'b1;
    frames(25);
    check("mrst_no_oob", oob_cnt - base, 0);
    check("mrst_x", circle_x, 160);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
